dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised single-port data memory with a request/ready handshake, registered read data, and a hardware initialisation sequencer. After reset or a soft clear, the sequencer sweeps the array one word per cycle, writing a default value and two programmable preset words. The block replaces the fixed 32x8 asynchronous-read data memory in the CPU datapath; the core's load/store stage drives it. Because the array has no asynchronous reset, synthesis can infer block RAM.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 5, address width in bits
- DEPTH, 32, number of words; must be at most 2**ADDR_WIDTH
- INIT_VAL, 0, value written to every ordinary word during the sweep
- PRE_ADDR_A, 8'h1B, first preset address
- PRE_VAL_A, 8'hFF, first preset value
- PRE_ADDR_B, 8'h1C, second preset address
- PRE_VAL_B, 8'hAA, second preset value

Ports (`clock` is the single clock; `reset` is asynchronous, active-high):
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  soft clear; restarts the init sweep
- req  in  1  access request
- we  in  1  1 = write, 0 = read; qualified by req
- Address  in  ADDR_WIDTH  word address
- Data_in  in  DATA_WIDTH  write data
- ready  out  1  block can accept a request this cycle
- busy  out  1  init sweep in progress
- rvalid  out  1  Data_out carries new read data; single-cycle pulse
- Data_out  out  DATA_WIDTH  registered read data
- err  out  1  out-of-range access; single-cycle pulse

## Operation
- The FSM has two states: INIT and IDLE. An init pointer `ptr` (ADDR_WIDTH bits) walks the array during INIT.
- Reset values: state = INIT, ptr = 0, ready = 0, busy = 1, rvalid = 0, err = 0, Data_out = 0. Memory contents are not reset.
- **INIT state:**
  - Each edge writes mem[ptr], then increments ptr.
  - The value written is PRE_VAL_A if ptr == PRE_ADDR_A, else PRE_VAL_B if ptr == PRE_ADDR_B, else INIT_VAL. A preset address at or above DEPTH is never written.
  - On the edge that writes ptr == DEPTH-1, the FSM moves to IDLE and ptr returns to 0.
  - Requests are ignored while in INIT.
- **IDLE state:**
  - busy = 0.
  - ready = ~clear. This is the only combinational output path.
  - A request is accepted when req && ready.
- **Accepted write:** mem[Address] <= Data_in at the same edge. No rvalid.
- **Accepted read:** Data_out <= mem[Address] at the same edge; rvalid = 1 for the following cycle.
- **Out-of-range access (Address >= DEPTH):**
  - A write is discarded.
  - A read loads Data_out with 0 and pulses rvalid.
  - Either access pulses err for one cycle.
- Data_out holds its last value between reads.
- **Clear:**
  - clear high in IDLE moves the FSM to INIT with ptr = 0 on the next edge.
  - Because ready is low during that cycle, a concurrent req is not accepted, and memory and Data_out are unchanged by that cycle's request.
  - clear asserted while already in INIT restarts the sweep at ptr = 0.
- Reset asserted mid-sweep or mid-access: state returns to INIT at once; any pending rvalid or err is cleared.

## Timing
- **Init latency:** DEPTH rising edges after reset is released (or after the edge that samples clear). Edge k writes address k-1. ready first reads 1 after edge DEPTH.
- **Read latency:** 1 cycle. Request at edge n gives Data_out and rvalid valid in cycle n..n+1.
- Back-to-back reads sustain one per cycle, and rvalid stays high continuously.
- **Read after write:** a write at edge n followed by a read of the same address at edge n+1 returns the new data. There is no bypass requirement within a single edge, because the block is single-port.
- A write to an address at edge n followed by a read of that address at edge n+1 returns Data_in.
- err and rvalid are registered and coincide for an out-of-range read.

## Test plan
- **Reset and sweep:** release reset with defaults. Required: ready = 0 for 32 cycles, then 1. Reads of 0x1B return 8'hFF, 0x1C returns 8'hAA, 0x00 and 0x1F return 8'h00, each with a 1-cycle rvalid.
- **Write/read:** write 8'h5A to 0x03, then read 0x03 on the next cycle. Required: Data_out = 8'h5A with rvalid one cycle after the read request. Back-to-back reads of 0x03 and 0x1B give rvalid high for 2 cycles, with data 5A then FF.
- **Clear versus request:** in IDLE, assert clear together with a write of 8'h77 to 0x05. Required: ready = 0 that cycle, and the write is dropped. After 32 cycles, a read of 0x05 returns 8'h00 and 0x1B is back to FF.
- **Out of range (DEPTH = 20, ADDR_WIDTH = 5):** write 8'h11 to 0x18, then read 0x18. Required: err pulses twice; the read returns 8'h00 with rvalid. The sweep lasts 20 cycles; presets 0x1B and 0x1C are skipped.
- **Reset mid-sweep:** assert reset at sweep cycle 10, release it, and repeat the read checks. Required: full 32-cycle sweep again, ready low throughout; rvalid and err are 0 during and immediately after reset.
- **Wide config (DATA_WIDTH = 16, ADDR_WIDTH = 6, DEPTH = 64, PRE_VAL_A = 16'hBEEF):** required: read 0x1B returns BEEF; a write then read of 0x3F with 16'hA5A5 returns A5A5.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Single-port data memory with req/ready handshake, registered read data and a
// power-on / soft-clear init sweep that writes a default value plus two presets.
module dmem_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DEPTH      = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
  parameter int                    PRE_ADDR_A = 'h1B,
  parameter logic [DATA_WIDTH-1:0] PRE_VAL_A  = 8'hFF,
  parameter int                    PRE_ADDR_B = 'h1C,
  parameter logic [DATA_WIDTH-1:0] PRE_VAL_B  = 8'hAA
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] Data_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  err
);

  typedef enum logic {INIT, IDLE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] ptr, ptr_d;
  logic                  mem_we, acc, in_range;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, sweep_val;
  logic [31:0]           ptr_x, addr_x;

  // No reset on the array so it maps onto block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign ptr_x    = 32'(ptr);
  assign addr_x   = 32'(Address);
  assign in_range = addr_x < 32'(DEPTH);
  assign busy     = (state == INIT);
  assign ready    = (state == IDLE) && !clear;

  // Presets at or above DEPTH never match because ptr stops at DEPTH-1.
  always_comb begin
    sweep_val = INIT_VAL;
    if (ptr_x == 32'(PRE_ADDR_A))      sweep_val = PRE_VAL_A;
    else if (ptr_x == 32'(PRE_ADDR_B)) sweep_val = PRE_VAL_B;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    mem_we    = 1'b0;
    mem_addr  = Address;
    mem_wdata = Data_in;
    acc       = 1'b0;
    case (state)
      INIT: begin
        if (clear) begin
          ptr_d = '0;
        end else begin
          mem_we    = 1'b1;
          mem_addr  = ptr;
          mem_wdata = sweep_val;
          if (ptr == LAST) begin
            state_d = IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr + 1'b1;
          end
        end
      end
      IDLE: begin
        if (clear) begin
          state_d = INIT;
          ptr_d   = '0;
        end else if (req) begin
          acc    = 1'b1;
          mem_we = we && in_range;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid   <= 1'b0;
      err      <= 1'b0;
      Data_out <= '0;
    end else begin
      rvalid <= acc && !we;
      err    <= acc && !in_range;
      if (acc && !we) Data_out <= in_range ? mem[Address] : '0;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (default, DEPTH=20, 16-bit/64-deep) share
// stimulus; each has a response scoreboard checked every falling edge.
module tb_dmem_ctrl;

  logic        clock = 1'b0;
  logic        rst, clr, we;
  logic [2:0]  req;
  logic [5:0]  addr;
  logic [15:0] din;
  logic [2:0]  ready_v, busy_v, rvalid_v, err_v;
  logic [7:0]  dout0, dout1;
  logic [15:0] dout2;
  logic [15:0] dout_v [3];

  int total = 0, bad = 0, cyc = 0;
  int depth [3] = '{32, 20, 64};

  typedef struct {int due; bit rd; bit er; logic [15:0] data;} exp_t;
  exp_t q [3][$];
  logic [15:0] m [3][64];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign dout_v[0] = {8'h00, dout0};
  assign dout_v[1] = {8'h00, dout1};
  assign dout_v[2] = dout2;

  dmem_ctrl u0 (
    .clock(clock), .reset(rst), .clear(clr), .req(req[0]), .we(we),
    .Address(addr[4:0]), .Data_in(din[7:0]), .ready(ready_v[0]), .busy(busy_v[0]),
    .rvalid(rvalid_v[0]), .Data_out(dout0), .err(err_v[0]));

  dmem_ctrl #(.DEPTH(20)) u1 (
    .clock(clock), .reset(rst), .clear(clr), .req(req[1]), .we(we),
    .Address(addr[4:0]), .Data_in(din[7:0]), .ready(ready_v[1]), .busy(busy_v[1]),
    .rvalid(rvalid_v[1]), .Data_out(dout1), .err(err_v[1]));

  dmem_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .DEPTH(64), .PRE_VAL_A(16'hBEEF),
              .PRE_VAL_B(16'h00AA)) u2 (
    .clock(clock), .reset(rst), .clear(clr), .req(req[2]), .we(we),
    .Address(addr), .Data_in(din), .ready(ready_v[2]), .busy(busy_v[2]),
    .rvalid(rvalid_v[2]), .Data_out(dout2), .err(err_v[2]));

  // Independent picture of memory contents after a sweep.
  task automatic init_models();
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < 64; a++)
        m[i][a] = (a == 'h1B) ? ((i == 2) ? 16'hBEEF : 16'h00FF) :
                  (a == 'h1C) ? 16'h00AA : 16'h0000;
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (q[i].size() > 0 && q[i][0].due == cyc) begin
        exp_t e;
        e = q[i].pop_front();
        total++;
        if (rvalid_v[i] !== e.rd || err_v[i] !== e.er) begin
          bad++;
          $display("FAIL resp%0d cyc=%0d: rvalid=%b err=%b, want rvalid=%b err=%b",
                   i, cyc, rvalid_v[i], err_v[i], e.rd, e.er);
        end
        if (e.rd) begin
          total++;
          if (dout_v[i] !== e.data) begin
            bad++;
            $display("FAIL rdata%0d cyc=%0d: got %h want %h", i, cyc, dout_v[i], e.data);
          end
        end
      end else begin
        total++;
        if (rvalid_v[i] !== 1'b0 || err_v[i] !== 1'b0) begin
          bad++;
          $display("FAIL idle%0d cyc=%0d: rvalid=%b err=%b, want 0 0",
                   i, cyc, rvalid_v[i], err_v[i]);
        end
      end
    end
  end

  // Drive one request for a cycle; if it is expected to be accepted, queue
  // the response due on the following cycle and update the model.
  task automatic access(input int inst, input bit w, input int a, input logic [15:0] d,
                        input bit acc);
    exp_t e;
    logic [15:0] dm;
    dm = (inst == 2) ? d : (d & 16'h00FF);
    req = '0; req[inst] = 1'b1; we = w; addr = 6'(a); din = d;
    if (acc) begin
      e.due = cyc + 1; e.rd = !w; e.er = (a >= depth[inst]);
      e.data = (!w && a < depth[inst]) ? m[inst][a] : 16'h0000;
      q[inst].push_back(e);
      if (w && a < depth[inst]) m[inst][a] = dm;
    end
    @(negedge clock);
    req = '0; we = 1'b0;
  endtask

  // Counts falling edges until each instance's ready rises.
  task automatic sweep_check(input string tag);
    int first [3] = '{-1, -1, -1};
    for (int n = 1; n <= 120; n++) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) if (first[i] < 0 && ready_v[i] === 1'b1) first[i] = n;
      if (first[0] >= 0 && first[1] >= 0 && first[2] >= 0) break;
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (first[i] != depth[i]) begin
        bad++;
        $display("FAIL %s_sweep%0d: ready after %0d edges, want %0d", tag, i, first[i], depth[i]);
      end
    end
    total++;
    if (busy_v !== 3'b000) begin
      bad++;
      $display("FAIL %s_busy: busy=%b want 000", tag, busy_v);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (ready_v !== 3'b000 || busy_v !== 3'b111 || rvalid_v !== 3'b000 || err_v !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: ready=%b busy=%b rvalid=%b err=%b, want 000 111 000 000",
               ready_v, busy_v, rvalid_v, err_v);
    end
    total++;
    if (dout0 !== 8'h00 || dout1 !== 8'h00 || dout2 !== 16'h0000) begin
      bad++;
      $display("FAIL reset_dout: %h %h %h want zeros", dout0, dout1, dout2);
    end
  endtask

  task automatic test_sweep();
    @(negedge clock); rst = 1'b0;
    sweep_check("init");
    access(0, 0, 'h1B, 0, 1);
    access(0, 0, 'h1C, 0, 1);
    access(0, 0, 'h00, 0, 1);
    access(0, 0, 'h1F, 0, 1);
    access(1, 0, 'h13, 0, 1);
    access(2, 0, 'h1C, 0, 1);
    @(negedge clock);
  endtask

  task automatic test_write_read();
    access(0, 1, 'h03, 16'h005A, 1);
    access(0, 0, 'h03, 0, 1);
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    access(0, 0, 'h03, 0, 1);
    access(0, 0, 'h1B, 0, 1);
    access(0, 1, 'h04, 16'h0033, 1);
    total++;
    if (dout0 !== 8'hFF) begin
      bad++;
      $display("FAIL hold_dout: got %h want ff", dout0);
    end
    access(0, 0, 'h04, 0, 1);
    @(negedge clock);
  endtask

  task automatic test_clear();
    clr = 1'b1; req = 3'b001; we = 1'b1; addr = 6'h05; din = 16'h0077;
    #1;
    total++;
    if (ready_v !== 3'b000) begin
      bad++;
      $display("FAIL clear_ready: ready=%b want 000", ready_v);
    end
    @(negedge clock);
    clr = 1'b0; req = '0; we = 1'b0;
    init_models();
    sweep_check("clear");
    access(0, 0, 'h05, 0, 1);
    access(0, 0, 'h1B, 0, 1);
    @(negedge clock);
  endtask

  task automatic test_out_of_range();
    access(1, 1, 'h18, 16'h0011, 1);
    access(1, 0, 'h18, 0, 1);
    access(1, 0, 'h1B, 0, 1);
    access(1, 1, 'h10, 16'h0042, 1);
    access(1, 0, 'h10, 0, 1);
    @(negedge clock);
  endtask

  task automatic test_wide();
    access(2, 0, 'h1B, 0, 1);
    access(2, 1, 'h3F, 16'hA5A5, 1);
    access(2, 0, 'h3F, 0, 1);
    access(2, 0, 'h3E, 0, 1);
    @(negedge clock);
  endtask

  task automatic test_reset_mid_sweep();
    access(0, 1, 'h1B, 16'h0012, 1);
    @(negedge clock);
    clr = 1'b1; @(negedge clock); clr = 1'b0;
    repeat (10) @(negedge clock);
    rst = 1'b1;
    #1;
    total++;
    if (rvalid_v !== 3'b000 || err_v !== 3'b000 || ready_v !== 3'b000 || busy_v !== 3'b111) begin
      bad++;
      $display("FAIL midrst_flags: rvalid=%b err=%b ready=%b busy=%b", rvalid_v, err_v, ready_v, busy_v);
    end
    repeat (2) @(negedge clock);
    rst = 1'b0;
    init_models();
    sweep_check("midrst");
    access(0, 0, 'h1B, 0, 1);
    access(0, 0, 'h1C, 0, 1);
    access(0, 0, 'h00, 0, 1);
    access(0, 0, 'h1F, 0, 1);
    @(negedge clock);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; req = '0; we = 1'b0; addr = '0; din = '0;
    init_models();
    test_reset();
    test_sweep();
    test_write_read();
    test_back_to_back();
    test_clear();
    test_out_of_range();
    test_wide();
    test_reset_mid_sweep();
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (q[i].size() != 0) begin
        bad++;
        $display("FAIL drain%0d: %0d responses outstanding, want 0", i, q[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
